// File: rtl/dm_wb_stage_pkg.sv
// dm_wb_stage_pkg: shared FSM encodings, wait-counter width and writeback-select helper.
package dm_wb_stage_pkg;
  localparam int DM_CNT_W = 4;
  typedef enum logic {DM_IDLE, DM_BUSY} dm_state_e;
  function automatic logic dm_use_mem(input logic memtoreg, input logic rd, input logic wr);
    return memtoreg && !(rd && wr);
  endfunction
endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port data RAM, synchronous write, asynchronous read.
module dm_ram #(
  parameter int DEPTH = 256,
  parameter int DSIZE = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DSIZE-1:0]         wdata,
  output logic [DSIZE-1:0]         rdata
);
  logic [DSIZE-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/dm_wb_stage.sv
// dm_wb_stage: data-memory access with wait states plus DM/WB register; DM_PERF_EN adds counters.
module dm_wb_stage
  import dm_wb_stage_pkg::*;
#(
  parameter int DSIZE       = 32,
  parameter int ASIZE       = 5,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] maddr_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic             memwrite_in,
  input  logic             memread_in,
  input  logic             memtoreg_in,
  input  logic             wen_in,
  output logic             stall,
  output logic [DSIZE-1:0] wb_data_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out
`ifdef DM_PERF_EN
  ,
  output logic [31:0]      load_cnt,
  output logic [31:0]      store_cnt,
  output logic [31:0]      stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DM_CNT_W-1:0] WC = DM_CNT_W'(WAIT_CYCLES);
  dm_state_e state;
  logic [DM_CNT_W-1:0] cnt;
  logic [DSIZE-1:0] rdata;
  logic access;
  assign access = memread_in | memwrite_in;
  always_comb
    stall = (state == DM_BUSY) ? (cnt > DM_CNT_W'(1)) : (access && WAIT_CYCLES != 0);
  // Gated by rst so a reset on the completing edge discards the store.
  dm_ram #(.DEPTH(DEPTH), .DSIZE(DSIZE)) u_ram (
    .clk  (clk),
    .we   (!stall && memwrite_in && !rst),
    .addr (maddr_in[AW-1:0]),
    .wdata(rdata2_in),
    .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= DM_IDLE;
      cnt         <= '0;
      wb_data_out <= '0;
      waddr_out   <= '0;
      wen_out     <= 1'b0;
    end else begin
      state   <= stall ? DM_BUSY : DM_IDLE;
      cnt     <= (state == DM_IDLE) ? (stall ? WC : '0) : cnt - 1'b1;
      wen_out <= !stall && wen_in;
      if (!stall) begin
        wb_data_out <= dm_use_mem(memtoreg_in, memread_in, memwrite_in) ? rdata : maddr_in;
        waddr_out   <= waddr_in;
      end
    end
`ifdef DM_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      load_cnt  <= load_cnt + 32'(!stall && memread_in && !memwrite_in);
      store_cnt <= store_cnt + 32'(!stall && memwrite_in);
      stall_cnt <= stall_cnt + 32'(stall);
    end
`endif
endmodule
